// File: rtl/ser_demux_pkg.sv
// Shared types and constants for the parametrised serial port demultiplexer:
// FSM state encoding, blank-digit constant and hex-to-segment lookup table.
package ser_demux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PORT,
        COUNT,
        DATA,
        DONE,
        PARITY
    } state_t;

    localparam logic [6:0] SSD_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high, digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational 4-bit hex digit to seven-segment pattern decoder.
module hex_to_ssd
    import ser_demux_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/ser_demux_n.sv
// Parametrised serial port demultiplexer. A framed packet (start 0, port
// number, data count, data bits) arrives one bit per debounced pushbutton
// strobe; data bits are routed to the addressed port via a one-hot select.
// Optional trailing even-parity bit: define SER_PARITY_EN.
module ser_demux_n
    import ser_demux_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int PORT_W      = $clog2(N_PORTS),
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clkPB,
    input  logic               SerIn,
    output logic [N_PORTS-1:0] P,
    output logic               serOut,
    output logic               serOut_valid,
    output logic               done,
    output logic               err,
    output logic [6:0]         SSD_OUT_LOW,
    output logic [6:0]         SSD_OUT_HIGH
);

    localparam int IDX_W = 4;
    localparam int SET_W = $clog2(SYNC_STAGES + 2);

`ifdef SER_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    logic [SYNC_STAGES-1:0] pb_sync;
    logic [SYNC_STAGES-1:0] si_sync;
    logic                   pb_prev;
    logic                   bit_stb;
    logic [SET_W-1:0]       settle_q;
    logic                   sin;

    state_t            state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              serout_q, serout_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
`ifdef SER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [7:0] disp;
    logic [6:0] seg_lo, seg_hi;

    assign sin = si_sync[SYNC_STAGES-1];

    // Synchronise the async inputs and emit a registered one-cycle strobe on
    // each clean rising edge of clkPB; edges seen while the synchroniser is
    // still refilling after reset are absorbed rather than reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            pb_sync  <= '0;
            si_sync  <= '0;
            pb_prev  <= 1'b0;
            bit_stb  <= 1'b0;
            settle_q <= SET_W'(SYNC_STAGES + 1);
        end else begin
            pb_sync <= {pb_sync[SYNC_STAGES-2:0], clkPB};
            si_sync <= {si_sync[SYNC_STAGES-2:0], SerIn};
            pb_prev <= pb_sync[SYNC_STAGES-1];
            bit_stb <= (settle_q == '0) && pb_sync[SYNC_STAGES-1] && !pb_prev;
            if (settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end
        end
    end

    // Frame FSM: next state plus next values of the field shifters and flags.
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        serout_d = serout_q;
        vld_d    = 1'b0;
        err_d    = err_q;
`ifdef SER_PARITY_EN
        par_d    = par_q;
        if (bit_stb && (state_q == PORT || state_q == COUNT || state_q == DATA)) begin
            par_d = par_q ^ sin;
        end
`endif
        case (state_q)
            IDLE: begin
                if (bit_stb && !sin) begin
                    state_d = PORT;
                    port_d  = '0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
`ifdef SER_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            PORT: begin
                if (bit_stb) begin
                    port_d = (port_q << 1) | PORT_W'(sin);
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_W'(PORT_W - 1)) begin
                        idx_d   = '0;
                        state_d = COUNT;
                        if (int'(port_d) >= N_PORTS) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            COUNT: begin
                if (bit_stb) begin
                    cnt_d = (cnt_q << 1) | CNT_W'(sin);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(CNT_W - 1)) begin
                        idx_d   = '0;
                        rem_d   = cnt_d;
                        state_d = (cnt_d == '0) ? AFTER_DATA : DATA;
                    end
                end
            end
            DATA: begin
                if (bit_stb) begin
                    serout_d = sin;
                    vld_d    = !err_q;
                    rem_d    = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = AFTER_DATA;
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (bit_stb) begin
                    if (sin != par_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            port_q   <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            serout_q <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef SER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            serout_q <= serout_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
`ifdef SER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign P            = (state_q == DATA && !err_q) ? (N_PORTS'(1) << port_q) : '0;
    assign serOut       = serout_q;
    assign serOut_valid = vld_q;
    assign done         = (state_q == DONE);
    assign err          = err_q;

    // Display value: remaining count while routing data, the partially
    // shifted count while receiving it, zero otherwise.
    always_comb begin
        disp = 8'h00;
        if (state_q == DATA) begin
            disp = 8'(rem_q);
        end else if (state_q == COUNT) begin
            disp = 8'(cnt_q);
        end
    end

    hex_to_ssd u_ssd_lo (
        .hex (disp[3:0]),
        .seg (seg_lo)
    );

    hex_to_ssd u_ssd_hi (
        .hex (disp[7:4]),
        .seg (seg_hi)
    );

    assign SSD_OUT_LOW  = seg_lo;
    assign SSD_OUT_HIGH = (CNT_W > 4) ? seg_hi : SSD_BLANK;

endmodule

// File: doc/ser_demux_n.md
Name: ser_demux_n

Overview:
- Parametrised successor to the fixed-format serial port demultiplexer (MSSD).
- Receives a framed serial packet on SerIn, one bit per debounced clkPB strobe. Frame is: start bit 0, PORT_W-bit port number, CNT_W-bit data count, then count data bits.
- Routes data bits to the addressed port with a one-hot P vector and serOut_valid.
- Shows the remaining data count on two seven-segment digits.
- Sits between the board pushbutton/switch inputs and the LED/SSD outputs.

Parameters:
- N_PORTS, 4, number of output ports; 2..16.
- PORT_W, $clog2(N_PORTS), port-number field width.
- CNT_W, 4, data-count field width; 1..8.
- SYNC_STAGES, 2, synchroniser depth for clkPB and SerIn; at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clkPB  in  1  asynchronous bit strobe from the pushbutton.
- SerIn  in  1  asynchronous serial data.
- P  out  N_PORTS  one-hot port select; held for the whole DATA phase.
- serOut  out  1  current routed data bit.
- serOut_valid  out  1  one-cycle pulse per accepted data bit.
- done  out  1  one-cycle pulse at end of frame.
- err  out  1  port number >= N_PORTS; held until the next start bit.
- SSD_OUT_LOW  out  7  remaining count, low nibble; segments {g,f,e,d,c,b,a}, active-high.
- SSD_OUT_HIGH  out  7  remaining count, high nibble; blank (0) when CNT_W <= 4.

Behaviour:
- Strobe generation:
  - clkPB and SerIn pass through SYNC_STAGES flops.
  - bit_stb is a one-cycle pulse on the synchronised rising edge of clkPB, SYNC_STAGES+1 clk after the clkPB edge.
  - SerIn is sampled on the bit_stb cycle.
- State machine, states IDLE, PORT, COUNT, DATA, DONE:
  - IDLE: on bit_stb with SerIn=0, go to PORT. SerIn=1 strobes are ignored.
  - PORT: shift PORT_W bits, MSB first. After the last bit, go to COUNT.
  - COUNT: shift CNT_W bits, MSB first. After the last bit, load rem = count. If count = 0, go to DONE; otherwise go to DATA.
  - DATA: each bit_stb registers serOut = SerIn, pulses serOut_valid for 1 clk (the cycle after bit_stb) and decrements rem. When rem reaches 0, go to DONE.
  - DONE: done = 1 for exactly one clk, then go to IDLE.
- P rules:
  - P = 1 << port throughout DATA, 0 in all other states.
  - If port >= N_PORTS: P = 0, err = 1, serOut_valid is suppressed, but data bits are still consumed so framing is preserved.
- SSD display:
  - SSDs show rem in DATA, the count being shifted in COUNT, and 0 otherwise.
  - Hex digits 0-F use the standard encoding.
- Reset (any time, including mid-frame): state = IDLE; shift registers and rem = 0; P = 0; serOut = 0; serOut_valid = 0; done = 0; err = 0; SSDs show "0" (7'h3F, HIGH = 0 when blank). Synchronisers clear to 0.
- A clkPB edge within SYNC_STAGES+1 clk after reset deassertion must not generate bit_stb while the synchroniser is still clearing.
- A strobe is never lost: every bit_stb is consumed in the cycle it is asserted.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined: a PARITY state follows DATA (or follows COUNT when count = 0). One extra bit is received; even parity is computed over the port, count and data bits. On mismatch err = 1, held until the next start bit. done still pulses.
- Undefined: no PARITY state; frame ends after the last data bit.

Decomposition:
- Package ser_demux_pkg holds:
  - the state enum (IDLE, PORT, COUNT, DATA, DONE, PARITY);
  - SSD_BLANK = 7'h00;
  - the hex-to-segment constant table.
- Sub-module hex_to_ssd: 4-bit in, 7-bit segments out, combinational, instantiated twice.
- The edge-detect and synchroniser stay inline.

Test Plan:
- Default params, frame 0 | 10 | 0011 | 1,0,1 -> P = 4'b0100 during DATA; three serOut_valid pulses with serOut = 1,0,1; SSD_LOW shows 3,2,1 then 0; done pulses once; err = 0.
- Count 0000 -> no serOut_valid; done pulses 1 clk after the last count bit's strobe; P stays 0.
- N_PORTS=3, port 11 -> err = 1, P = 0, data bits consumed with no valid; the next good frame clears err and routes correctly.
- Reset asserted mid-DATA (after 2 of 5 bits) -> next clk: all outputs at reset values; a following fresh frame decodes correctly.
- Idle-line strobes with SerIn = 1 x4, then a normal frame -> the ignored strobes cause no state change, and the frame decodes.
- CNT_W=8, count 8'h2A -> SSD_HIGH = "2", SSD_LOW = "A"; after 42 valid pulses, done.
- With SER_PARITY_EN defined: a wrong parity bit sets err = 1 and done still pulses.
